// File: rtl/counter_pkg.sv
// Shared definitions for the display refresh path: controller state encoding,
// blank segment code and the BCD-to-7-segment mapping.
package counter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_LATCH    = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    SHIFT_LO = ST_SHIFT_LO,
    SHIFT_HI = ST_SHIFT_HI,
    LATCH    = ST_LATCH
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Segment byte is {dp,g,f,e,d,c,b,a}, active high; non-BCD codes blank the digit.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to 7-segment byte encoder.
module seg7_encode
  import counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/display_refresh_ctrl.sv
// Refresh sequencer: snapshots the BCD digits, encodes them to 7-segment and
// shifts the frame MSB-first into external shift registers, then strobes the latch.
module display_refresh_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned DIGITS  = 6,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ref_clk,
  input  logic [4*DIGITS-1:0] digits,
  output logic                seg_data,
  output logic                seg_sclk,
  output logic                seg_latch,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned N     = 8 * DIGITS;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [N-1:0] frame_c;

  // Most significant digit lands in the top byte so it leaves first.
  for (genvar i = 0; i < DIGITS; i++) begin : g_enc
    seg7_encode u_enc (
      .bcd (digits[4*i +: 4]),
      .seg (frame_c[8*i +: 8])
    );
  end

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic             pending_q, pending_d;
  logic             seg_data_q, seg_data_d;
  logic             seg_sclk_q, seg_sclk_d;
  logic             seg_latch_q, seg_latch_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             div_done;

  assign div_done = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    pending_d = pending_q;
    overrun_d = 1'b0;

    // A request during a transfer is held once; a second one is dropped.
    if (state_q != IDLE && ref_clk) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ref_clk) begin
          state_d = SHIFT_LO;
          shreg_d = frame_c;
          cnt_d   = '0;
          div_d   = '0;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          div_d   = '0;
          shreg_d = shreg_q << 1;
          if (cnt_q == CNT_LAST) begin
            state_d = LATCH;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_done) begin
          div_d = '0;
          // A held request, or one arriving on this very edge, reloads without idling.
          if (pending_q || ref_clk) begin
            pending_d = 1'b0;
            state_d   = SHIFT_LO;
            shreg_d   = frame_c;
            cnt_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    endcase

    seg_sclk_d  = (state_d == SHIFT_HI);
    seg_latch_d = (state_d == LATCH);
    busy_d      = (state_d != IDLE);
    seg_data_d  = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? shreg_d[N-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      pending_q   <= 1'b0;
      seg_data_q  <= 1'b0;
      seg_sclk_q  <= 1'b0;
      seg_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      pending_q   <= pending_d;
      seg_data_q  <= seg_data_d;
      seg_sclk_q  <= seg_sclk_d;
      seg_latch_q <= seg_latch_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign seg_data  = seg_data_q;
  assign seg_sclk  = seg_sclk_q;
  assign seg_latch = seg_latch_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Bench for display_refresh_ctrl: a default instance and a DIGITS=1/CLK_DIV=1
// instance, driven randomly and scored against a frame-timing reference model.
module tb_display_refresh_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rc;
  logic [23:0] dg0;
  logic [3:0]  dg1;
  logic sd0, sc0, sl0, bz0, ov0;
  logic sd1, sc1, sl1, bz1, ov1;
  logic [1:0] sd, sc, sl, bz, ov;

  assign sd = {sd1, sd0};
  assign sc = {sc1, sc0};
  assign sl = {sl1, sl0};
  assign bz = {bz1, bz0};
  assign ov = {ov1, ov0};

  always #5 clk = ~clk;

  display_refresh_ctrl u_dut0 (
    .clk(clk), .reset(reset), .ref_clk(rc[0]), .digits(dg0),
    .seg_data(sd0), .seg_sclk(sc0), .seg_latch(sl0), .busy(bz0), .overrun(ov0)
  );

  display_refresh_ctrl #(.DIGITS(1), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .ref_clk(rc[1]), .digits(dg1),
    .seg_data(sd1), .seg_sclk(sc1), .seg_latch(sl1), .busy(bz1), .overrun(ov1)
  );

  localparam logic [7:0] SEG_TAB [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic int nd(input int u);   return (u == 0) ? 6 : 1; endfunction
  function automatic int cdiv(input int u); return (u == 0) ? 4 : 1; endfunction
  function automatic int nb(input int u);   return 8 * nd(u); endfunction
  function automatic int flen(input int u); return (2 * nb(u) + 1) * cdiv(u); endfunction
  function automatic logic [23:0] dig(input int u);
    return (u == 0) ? dg0 : {20'h0, dg1};
  endfunction

  // Expected bit stream, right-aligned, most significant digit first.
  function automatic logic [47:0] enc(input logic [23:0] d, input int n);
    logic [47:0] r;
    logic [3:0]  x;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      x = d[4*i +: 4];
      r = {r[39:0], SEG_TAB[x]};
    end
    return r;
  endfunction

  typedef struct { int u; logic [47:0] f; } fr_t;
  typedef struct { int u; int s; int len; } bz_t;
  typedef struct { int u; int c; } ov_t;
  fr_t fq[$];
  bz_t bq[$];
  ov_t oq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int u, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s u%0d at cycle %0d: got=%0h exp=%0h", nm, u, cyc, got, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int u);
    total++;
    bad++;
    $display("FAIL %s u%0d at cycle %0d: event with no expectation", nm, u, cyc);
  endtask

  // Reference model: frames occupy a fixed span; one request may wait behind a frame.
  bit m_act  [2] = '{0, 0};
  bit m_pend [2] = '{0, 0};
  int m_end  [2] = '{0, 0};
  int m_run  [2] = '{0, 0};

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        for (int i = fq.size() - 1; i >= 0; i--)
          if (fq[i].u == u) fq.delete(i);
        m_act[u]  = 0;
        m_pend[u] = 0;
      end else if (m_act[u] && cyc == m_end[u]) begin
        if (m_pend[u] && rc[u]) oq.push_back('{u, cyc});
        if (m_pend[u] || rc[u]) begin
          fq.push_back('{u, enc(dig(u), nd(u))});
          m_end[u] = cyc + flen(u);
        end else begin
          bq.push_back('{u, m_run[u], cyc - m_run[u]});
          m_act[u] = 0;
        end
        m_pend[u] = 0;
      end else if (m_act[u] && rc[u]) begin
        if (m_pend[u]) oq.push_back('{u, cyc});
        else           m_pend[u] = 1;
      end else if (!m_act[u] && rc[u]) begin
        m_act[u] = 1;
        m_run[u] = cyc;
        fq.push_back('{u, enc(dig(u), nd(u))});
        m_end[u] = cyc + flen(u);
      end
    end
  end

  function automatic int find_fr(input int u);
    for (int i = 0; i < fq.size(); i++) if (fq[i].u == u) return i;
    return -1;
  endfunction
  function automatic int find_bz(input int u);
    for (int i = 0; i < bq.size(); i++) if (bq[i].u == u) return i;
    return -1;
  endfunction
  function automatic int find_ov(input int u);
    for (int i = 0; i < oq.size(); i++) if (oq[i].u == u) return i;
    return -1;
  endfunction

  // Monitor: reassembles the serial stream and pops expectations on each event.
  logic        p_sc [2] = '{0, 0};
  logic        p_sl [2] = '{0, 0};
  logic        p_sd [2] = '{0, 0};
  logic        p_bz [2] = '{0, 0};
  logic [47:0] cap  [2] = '{48'h0, 48'h0};
  int          nbits[2] = '{0, 0};
  int          lw   [2] = '{0, 0};
  int          bst  [2] = '{0, 0};

  always @(negedge clk) begin
    int idx;
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        chk("reset_outputs", u, 64'({sd[u], sc[u], sl[u], bz[u], ov[u]}), 64'h0);
        p_sc[u] = 0; p_sl[u] = 0; p_sd[u] = 0; p_bz[u] = 0;
        cap[u] = '0; nbits[u] = 0; lw[u] = 0;
      end else begin
        if (sc[u] && !p_sc[u]) begin
          cap[u] = {cap[u][46:0], sd[u]};
          nbits[u]++;
        end
        if (sc[u] && p_sc[u]) chk("data_hold", u, 64'(sd[u]), 64'(p_sd[u]));
        if (sl[u]) begin
          lw[u]++;
          chk("latch_quiet", u, 64'({sd[u], sc[u]}), 64'h0);
        end
        if (sl[u] && !p_sl[u]) begin
          chk("frame_bits", u, 64'(nbits[u]), 64'(nb(u)));
          idx = find_fr(u);
          if (idx < 0) fail_now("frame_unexpected", u);
          else begin
            chk("frame_data", u, 64'(cap[u]), 64'(fq[idx].f));
            fq.delete(idx);
          end
          cap[u] = '0;
          nbits[u] = 0;
        end
        if (!sl[u] && p_sl[u]) begin
          chk("latch_width", u, 64'(lw[u]), 64'(cdiv(u)));
          lw[u] = 0;
        end
        if (bz[u] && !p_bz[u]) bst[u] = cyc;
        if (!bz[u] && p_bz[u]) begin
          idx = find_bz(u);
          if (idx < 0) fail_now("busy_unexpected", u);
          else begin
            chk("busy_start", u, 64'(bst[u]), 64'(bq[idx].s));
            chk("busy_len", u, 64'(cyc - bst[u]), 64'(bq[idx].len));
            bq.delete(idx);
          end
        end
        if (ov[u]) begin
          idx = find_ov(u);
          if (idx < 0) fail_now("overrun_unexpected", u);
          else begin
            chk("overrun_cycle", u, 64'(cyc), 64'(oq[idx].c));
            oq.delete(idx);
          end
        end
        p_sc[u] = sc[u]; p_sl[u] = sl[u]; p_sd[u] = sd[u]; p_bz[u] = bz[u];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Request sampled on the next clock edge.
  task automatic pulse(input int u);
    rc[u] = 1'b1;
    step();
    rc[u] = 1'b0;
  endtask

  function automatic logic [23:0] rand_digits();
    logic [23:0] r;
    for (int i = 0; i < 6; i++)
      r[4*i +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    int g;
    reset = 1'b1;
    rc    = '0;
    dg0   = '0;
    dg1   = '0;
    steps(3);
    reset = 1'b0;
    steps(2);

    dg0 = 24'h123456;
    pulse(0);
    steps(400);

    dg0 = 24'hABCDEF;
    pulse(0);
    steps(400);

    // Reload at cycle 100; digits present only at the reload edge are used.
    dg0 = rand_digits();
    pulse(0);
    steps(99);
    pulse(0);
    steps(287);
    dg0 = 24'h908172;
    step();
    dg0 = rand_digits();
    steps(400);

    // Second and third request in one frame: third is dropped.
    dg0 = rand_digits();
    pulse(0);
    steps(49);
    pulse(0);
    steps(99);
    pulse(0);
    steps(900);

    // Reset mid-frame aborts without latching.
    dg0 = rand_digits();
    pulse(0);
    steps(199);
    reset = 1'b1;
    #1;
    chk("reset_async", 0, 64'({sd0, sc0, sl0, bz0, ov0}), 64'h0);
    steps(2);
    reset = 1'b0;
    steps(5);
    dg0 = 24'h246801;
    pulse(0);
    steps(400);

    // Single-digit instance: request on the latch-exit edge chains frames.
    dg1 = 4'h8;
    pulse(1);
    steps(16);
    pulse(1);
    steps(40);
    for (int i = 0; i < 12; i++) begin
      dg1 = 4'($urandom_range(0, 15));
      pulse(1);
      steps($urandom_range(0, 25));
    end
    steps(40);

    for (int i = 0; i < 12; i++) begin
      dg0 = rand_digits();
      pulse(0);
      g = $urandom_range(0, 450);
      steps(g / 2);
      dg0 = rand_digits();
      steps(g - g / 2);
    end
    steps(900);

    chk("frames_left", 0, 64'(fq.size()), 64'h0);
    chk("busy_left", 0, 64'(bq.size()), 64'h0);
    chk("overrun_left", 0, 64'(oq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
